// File: rtl/buyruk_getir.sv
// Instruction fetch stage: PC, memory read address, prefetch FIFO and decode handshake.
// Optional fetch/stall counters are built when GETIR_SAYAC_EN is defined.
module buyruk_getir #(
  parameter logic [31:0] BASLANGIC_ADRES = 32'h0000_0000,
  parameter int unsigned FIFO_DERINLIK   = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] bellek_adres_o,
  input  logic [31:0] bellek_veri_i,
  input  logic        bellek_mesgul_i,
  input  logic        dallan_i,
  input  logic [31:0] dallan_adres_i,
  output logic [31:0] buyruk_o,
  output logic [31:0] buyruk_pc_o,
  output logic        gecerli_o,
  input  logic        hazir_i
`ifdef GETIR_SAYAC_EN
  ,
  output logic [31:0] getirilen_o,
  output logic [31:0] bekleme_o
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DERINLIK);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned AW = 32;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [AW-1:0] buyruk;
  } giris_t;

  giris_t          fifo_q [FIFO_DERINLIK];
  logic [AW-1:0]   pc_r;
  logic [PW-1:0]   yaz_ptr_r;
  logic [PW-1:0]   oku_ptr_r;
  logic [CW-1:0]   sayi_r;

  logic            bos_c;
  logic            dolu_c;
  logic            pop_c;
  logic            push_c;
  logic [AW-1:0]   hedef_c;
  giris_t          bas_c;

  // Handshake decisions; a redirect cancels both push and pop.
  always_comb begin
    bos_c   = (sayi_r == '0);
    dolu_c  = (sayi_r == CW'(FIFO_DERINLIK));
    pop_c   = !bos_c && hazir_i && !dallan_i;
    push_c  = !dallan_i && !bellek_mesgul_i && (!dolu_c || pop_c);
    hedef_c = dallan_adres_i & ~AW'(3);
  end

  // PC, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_r      <= BASLANGIC_ADRES;
      yaz_ptr_r <= '0;
      oku_ptr_r <= '0;
      sayi_r    <= '0;
    end else if (dallan_i) begin
      pc_r      <= hedef_c;
      yaz_ptr_r <= '0;
      oku_ptr_r <= '0;
      sayi_r    <= '0;
    end else begin
      if (push_c) begin
        pc_r      <= pc_r + AW'(4);
        yaz_ptr_r <= yaz_ptr_r + PW'(1);
      end
      if (pop_c) begin
        oku_ptr_r <= oku_ptr_r + PW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   sayi_r <= sayi_r + CW'(1);
        2'b01:   sayi_r <= sayi_r - CW'(1);
        default: sayi_r <= sayi_r;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      fifo_q[yaz_ptr_r] <= '{pc: pc_r, buyruk: bellek_veri_i};
    end
  end

  always_comb begin
    bas_c          = fifo_q[oku_ptr_r];
    gecerli_o      = !bos_c;
    buyruk_o       = bos_c ? '0 : bas_c.buyruk;
    buyruk_pc_o    = bos_c ? '0 : bas_c.pc;
    bellek_adres_o = pc_r;
  end

`ifdef GETIR_SAYAC_EN
  // Pushes and empty-head cycles; redirects do not clear them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      getirilen_o <= '0;
      bekleme_o   <= '0;
    end else begin
      if (push_c) begin
        getirilen_o <= getirilen_o + AW'(1);
      end
      if (bos_c) begin
        bekleme_o <= bekleme_o + AW'(1);
      end
    end
  end
`endif

endmodule
